iter_alu: RTL
=============

# iter_alu

Multi-cycle, parametrised execution unit for the next-generation datapath, replacing the purely combinational ALU. Single-cycle logic/arithmetic ops return a registered result one clock after issue. Unsigned multiply and divide run iteratively over WIDTH cycles, producing a double-width Hi/Lo result. A Start/Busy/Done handshake lets the control unit stall while the unit works.

## Interface
- WIDTH, 32: operand and result width; legal range 4..64, must be even.
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- Start  input  1  issue request; sampled on rising CLK while Busy=0.
- SrcA  input  WIDTH  operand A; captured when Start is accepted.
- SrcB  input  WIDTH  operand B; captured when Start is accepted.
- ALUControl  input  4  operation select; captured with operands.
- ALUResult  output  WIDTH  result low word (quotient for DIVU, product low for MULU).
- ALUResultHi  output  WIDTH  product high word (MULU), remainder (DIVU), 0 for all other ops.
- Zero  output  1  ALUResult == 0; derived from the registered ALUResult.
- Busy  output  1  iterative op in progress; Start ignored while high.
- Done  output  1  one-cycle pulse; results valid from this cycle until the next accepted Start.
- DivByZero  output  1  set with Done of a DIVU whose SrcB was 0; cleared on next accepted Start.

## Operation
- Encodings: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB, 0101 MULU, 0110 SLT (signed), 0111 SLTU, 1000 DIVU, 1001 NOR. Any other code completes in one cycle with ALUResult=0 and ALUResultHi=0.
- ADD and SUB wrap modulo 2^WIDTH. There is no overflow output.
- SLT and SLTU return 1 or 0 in bit 0; upper bits are 0.
- MULU: shift-add, one multiplier bit per cycle, WIDTH iterations. Result {ALUResultHi, ALUResult} = A*B as an exact 2*WIDTH-bit product.
- DIVU: restoring division, one quotient bit per cycle, WIDTH iterations. ALUResult=A/B, ALUResultHi=A%B.
- DIVU with B=0: still takes the full latency. Result is ALUResult=all ones, ALUResultHi=A, DivByZero=1.
- State machine:
  - IDLE. Start with a single-cycle op goes to DONE. Start with MULU or DIVU loads the operands, clears the iteration counter, and goes to RUN.
  - RUN. One iteration per cycle; Busy=1. After the WIDTH-th iteration, go to DONE.
  - DONE. Done=1 and Busy=0. A Start in this cycle is accepted (back-to-back issue) with the same transitions as from IDLE; otherwise go to IDLE.
- Iteration counter width is $clog2(WIDTH+1).
- Output registers update only on entry to DONE and hold otherwise.

## Timing
- Start accepted at edge N.
  - Single-cycle op: Done=1 and results valid after edge N+1.
  - MULU/DIVU: Busy=1 after edges N+1..N+WIDTH, Done=1 after edge N+WIDTH+1. Latency is WIDTH+1 cycles.
- Start while Busy=1 is ignored. It has no effect on state, operands or outputs.
- Start and Done in the same cycle: the new op is accepted, Done drops next cycle, and results stay unchanged until the new op's Done.
- Reset values: ALUResult=0, ALUResultHi=0, Zero=1, Busy=0, Done=0, DivByZero=0, state=IDLE.
- RST during RUN immediately abandons the operation to the reset state. No Done is produced.
- Operand inputs may change freely after acceptance.

## Structure
- Package iter_alu_pkg:
  - ALUControl encoding localparams.
  - State enum (IDLE, RUN, DONE).
  - Width of the ALUControl field.
- Sub-module iter_muldiv: the WIDTH-iteration shift-add/restoring datapath with a mode input.
- Top level holds the FSM, the single-cycle ops, and the output registers.

## Test plan
- Reset then idle, WIDTH=32 -> all outputs at reset values, Zero=1; Start held low keeps Done=0.
- ADD 0xFFFFFFFF+1 -> Done one cycle later, ALUResult=0, Zero=1. SLT 0xFFFFFFFF,1 -> 1. SLTU with the same operands -> 0.
- MULU 0xFFFFFFFF*0xFFFFFFFF -> Busy for 32 cycles, Done at cycle 33, Hi=0xFFFFFFFE, Lo=0x00000001.
- DIVU 100/7 -> Lo=14, Hi=2, DivByZero=0. DIVU 5/0 -> Lo=0xFFFFFFFF, Hi=5, DivByZero=1, latency 33 cycles.
- Start pulsed during MULU Busy is ignored. A Start on the Done cycle is accepted and back-to-back results are correct.
- RST asserted mid-DIVU -> outputs return to reset values at once, no Done pulse. Repeat MULU with WIDTH=8: 255*255 -> Hi=0xFE, Lo=0x01.

Source files
------------

// File: rtl/iter_alu_pkg.sv
// Shared definitions for the iterative ALU: operation encodings, FSM state
// constants and a helper that classifies multi-cycle operations.
package iter_alu_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] OP_AND  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] OP_OR   = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] OP_XOR  = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] OP_SUB  = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] OP_MULU = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] OP_SLT  = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] OP_SLTU = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] OP_DIVU = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] OP_NOR  = 4'b1001;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic is_iter_op(input logic [ALU_CTRL_W-1:0] op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// One-bit-per-cycle datapath: shift-add unsigned multiply (mode=0) or
// restoring unsigned divide (mode=1). Exposes the value after the next step.
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi_next
);

  // acc_hi: product high / partial remainder; acc_lo: multiplier / quotient
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    // One extra bit so a zero divisor never borrows: quotient fills with ones
    // and the remainder ends up holding the dividend.
    div_diff  = {1'b0, div_shift} - {2'b00, opb};
    lo_next   = acc_lo;
    hi_next   = acc_hi;
    if (!mode) begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (!div_diff[WIDTH+1]) begin
      hi_next = div_diff[WIDTH-1:0];
      lo_next = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_next = div_shift[WIDTH-1:0];
      lo_next = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
    end else if (load) begin
      acc_hi <= '0;
      acc_lo <= a;
      opb    <= b;
    end else if (step) begin
      acc_hi <= hi_next;
      acc_lo <= lo_next;
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle ops complete one clock after issue, MULU/DIVU
// iterate WIDTH cycles. Handshake: start is accepted on a rising edge whenever
// busy=0; done pulses for one cycle and results hold until the next op's done.
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      srca,
  input  logic [WIDTH-1:0]      srcb,
  input  logic [ALU_CTRL_W-1:0] alucontrol,
  output logic [WIDTH-1:0]      aluresult,
  output logic [WIDTH-1:0]      aluresulthi,
  output logic                  zero,
  output logic                  busy,
  output logic                  done,
  output logic                  divbyzero,
  output state_t                state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt;
  logic             op_div_q;
  logic             b_zero_q;
  logic             accept;
  logic             iter_op;
  logic             last_iter;
  logic [WIDTH-1:0] sc_result;
  logic [WIDTH-1:0] md_lo_next;
  logic [WIDTH-1:0] md_hi_next;

  assign accept    = start && (state != ST_RUN);
  assign iter_op   = is_iter_op(alucontrol);
  assign last_iter = (state == ST_RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign zero      = (aluresult == '0);

  always_comb begin
    sc_result = '0;
    case (alucontrol)
      OP_AND:  sc_result = srca & srcb;
      OP_OR:   sc_result = srca | srcb;
      OP_ADD:  sc_result = srca + srcb;
      OP_XOR:  sc_result = srca ^ srcb;
      OP_SUB:  sc_result = srca - srcb;
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, srca < srcb};
      OP_NOR:  sc_result = ~(srca | srcb);
      default: sc_result = '0;
    endcase
  end

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .load    (accept && iter_op),
    .step    (state == ST_RUN),
    .mode    (op_div_q),
    .a       (srca),
    .b       (srcb),
    .lo_next (md_lo_next),
    .hi_next (md_hi_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      op_div_q    <= 1'b0;
      b_zero_q    <= 1'b0;
      aluresult   <= '0;
      aluresulthi <= '0;
      divbyzero   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            aluresult   <= md_lo_next;
            aluresulthi <= md_hi_next;
            divbyzero   <= op_div_q && b_zero_q;
            state       <= ST_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new op, giving back-to-back issue
          if (accept) begin
            divbyzero <= 1'b0;
            if (iter_op) begin
              cnt      <= '0;
              op_div_q <= (alucontrol == OP_DIVU);
              b_zero_q <= (srcb == '0);
              state    <= ST_RUN;
            end else begin
              aluresult   <= sc_result;
              aluresulthi <= '0;
              state       <= ST_DONE;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
